// File: rtl/mips_key_irq_if.sv
// Coprocessor bus between the MIPS core and the key/interrupt peripheral.
//   addr_i     : bus address from the core
//   dmem_ctl_i : command (0 idle, 1 load word, 2 store word, others ignored)
//   din        : store data from the core
//   dout       : load data back to the core
// The master modport is the core side. The slave modport is the peripheral side.
interface mips_key_irq_if;
  logic [31:0] addr_i;
  logic [3:0]  dmem_ctl_i;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output addr_i, output dmem_ctl_i, output din, input dout);
  modport slave  (input addr_i, input dmem_ctl_i, input din, output dout);
endinterface

// File: rtl/mips_key_irq.sv
// Debounced push-button interrupt source with a three-register bus window.
//   clk        : sole clock, rising edge
//   rst        : asynchronous, active-low reset
//   key_i      : raw push-button, asynchronous to clk, low = pressed
//   bus        : coprocessor bus (slave side): addr_i, dmem_ctl_i, din -> dout
//   irq_o      : registered level interrupt (pending AND irq_en)
//   irq_addr_o : interrupt vector, software-writable through VECTOR
// Register map, as offsets from BASE_ADDR:
//   0x0 STATUS (read only) : {press_cnt[15:8], irq_en[2], key level[1], pending[0]}
//   0x4 CTRL (write only)  : din[0] -> irq_en, din[1] = 1 clears pending
//   0x8 VECTOR (read/write): irq_addr_o
module mips_key_irq #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_2000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] IRQ_VEC         = 32'h0000_0050
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_i,
  mips_key_irq_if.slave      bus,
  output logic               irq_o,
  output logic [31:0]        irq_addr_o
);

  typedef enum logic [3:0] {
    CMD_IDLE  = 4'h0,
    CMD_LOAD  = 4'h1,
    CMD_STORE = 4'h2
  } cmd_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_STATUS,
    SEL_CTRL,
    SEL_VECTOR
  } sel_e;

  localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

  logic        key_s1, key_s2;
  logic        stable;
  logic [15:0] db_cnt;
  logic        pending;
  logic        irq_en;
  logic [7:0]  press_cnt;
  sel_e        sel;
  logic        is_load, is_store;
  logic        press_evt;
  logic        ctrl_wr;
  logic [31:0] status_val;

  // Address decode. Addresses outside the three-register window select nothing.
  // NOTE: every signal assigned in always_comb gets a default first. Without it,
  // a missed branch would infer a latch.
  always_comb begin
    sel = SEL_NONE;
    if (bus.addr_i == BASE_ADDR)                 sel = SEL_STATUS;
    else if (bus.addr_i == BASE_ADDR + 32'h4)    sel = SEL_CTRL;
    else if (bus.addr_i == BASE_ADDR + 32'h8)    sel = SEL_VECTOR;
  end

  assign is_load    = (bus.dmem_ctl_i == CMD_LOAD);
  assign is_store   = (bus.dmem_ctl_i == CMD_STORE);
  assign ctrl_wr    = is_store && (sel == SEL_CTRL);
  assign status_val = {16'h0, press_cnt, 5'b0, irq_en, stable, pending};

  // A press is the debounced level falling. The event is raised in the same
  // cycle that the debouncer accepts the new level.
  assign press_evt = stable && !key_s2 && (db_cnt == CNT_LAST);

  // A two-flop synchronizer. It presets to 1 (released), so reset release does not
  // look like a press.
  // NOTE: an asynchronous reset is in the sensitivity list, so reset takes effect
  // without a clock. Sequential state always uses non-blocking (<=) assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_i;
      key_s2 <= key_s1;
    end
  end

  // Debounce. A change is accepted only after DEBOUNCE_CYCLES consecutive
  // differing samples. Any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= 1'b1;
      db_cnt <= 16'h0;
    end else if (key_s2 == stable) begin
      db_cnt <= 16'h0;
    end else if (db_cnt == CNT_LAST) begin
      stable <= key_s2;
      db_cnt <= 16'h0;
    end else begin
      db_cnt <= db_cnt + 16'h1;
    end
  end

  // Pending, enable and counter. When a press event and a clear arrive in the
  // same cycle, the set wins, so an interrupt is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending   <= 1'b0;
      irq_en    <= 1'b0;
      press_cnt <= 8'h0;
    end else begin
      if (press_evt)                pending <= 1'b1;
      else if (ctrl_wr && bus.din[1]) pending <= 1'b0;
      if (ctrl_wr)   irq_en    <= bus.din[0];
      if (press_evt) press_cnt <= press_cnt + 8'h1;
    end
  end

  // Vector register, the registered interrupt output, and the load data path.
  // dout changes only on a load. It holds its value on all other cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_addr_o <= IRQ_VEC;
      irq_o      <= 1'b0;
      bus.dout   <= 32'h0;
    end else begin
      irq_o <= pending && irq_en;
      if (is_store && (sel == SEL_VECTOR)) irq_addr_o <= bus.din;
      if (is_load) begin
        unique case (sel)
          SEL_STATUS: bus.dout <= status_val;
          SEL_VECTOR: bus.dout <= irq_addr_o;
          default:    bus.dout <= 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_key_irq.sv
// Self-checking bench for mips_key_irq with DEBOUNCE_CYCLES = 4.
// The bench drives inputs on falling edges and samples outputs on falling edges.
// Load results pass through a scoreboard. Each load pushes its expected dout.
// A monitor pops the expected value and compares it one cycle after the load.
module tb_mips_key_irq;

  localparam logic [31:0] BASE   = 32'h0000_2000;
  localparam logic [31:0] STATUS = BASE;
  localparam logic [31:0] CTRL   = BASE + 32'h4;
  localparam logic [31:0] VECTOR = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_i;
  logic        irq_o;
  logic [31:0] irq_addr_o;

  mips_key_irq_if bus();

  mips_key_irq #(
    .BASE_ADDR       (BASE),
    .DEBOUNCE_CYCLES (16'd4),
    .IRQ_VEC         (32'h0000_0050)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_i      (key_i),
    .bus        (bus),
    .irq_o      (irq_o),
    .irq_addr_o (irq_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor. A load seen on a rising edge is checked at the following falling edge.
  logic load_seen;
  always @(posedge clk or negedge rst) begin
    if (!rst) load_seen <= 1'b0;
    else      load_seen <= (bus.dmem_ctl_i == 4'h1);
  end

  always @(negedge clk) begin
    if (load_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got load result %h, expected no load", bus.dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, bus.dout, e.val);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.val  = exp;
    exp_q.push_back(e);
    bus.addr_i     = addr;
    bus.dmem_ctl_i = 4'h1;
    @(negedge clk);
    bus.dmem_ctl_i = 4'h0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
    bus.addr_i     = addr;
    bus.din        = data;
    bus.dmem_ctl_i = 4'h2;
    @(negedge clk);
    bus.dmem_ctl_i = 4'h0;
  endtask

  task automatic press();
    key_i = 1'b0;
    cycles(7);
    key_i = 1'b1;
    cycles(7);
  endtask

  task automatic wait_irq(input logic exp, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (irq_o === exp) break;
      @(negedge clk);
    end
    check(name, {31'h0, irq_o}, {31'h0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b0;
    key_i          = 1'b1;
    bus.addr_i     = 32'h0;
    bus.dmem_ctl_i = 4'h0;
    bus.din        = 32'h0;
    cycles(3);
    check("rst_dout", bus.dout, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    check("rst_vec", irq_addr_o, 32'h0000_0050);
    rst = 1'b1;
    cycles(1);

    // Reset state visible through the bus.
    do_load(STATUS, 32'h0000_0002, "status_after_reset");
    do_load(VECTOR, 32'h0000_0050, "vector_after_reset");
    check("irq_idle", {31'h0, irq_o}, 32'h0);

    // Enable the interrupt, then make one debounced press.
    do_store(CTRL, 32'h1);
    key_i = 1'b0;
    cycles(5);
    check("irq_not_early", {31'h0, irq_o}, 32'h0);
    wait_irq(1'b1, 3, "irq_on_press");
    cycles(3);
    do_load(STATUS, 32'h0000_0105, "status_pressed");
    key_i = 1'b1;
    cycles(8);
    do_load(STATUS, 32'h0000_0107, "status_released_no_event");

    // Write-one-to-clear. irq_o drops one cycle after pending clears.
    do_store(CTRL, 32'h3);
    check("irq_hold_after_clear", {31'h0, irq_o}, 32'h1);
    cycles(1);
    check("irq_dropped", {31'h0, irq_o}, 32'h0);
    do_load(STATUS, 32'h0000_0106, "status_cleared");

    // Glitches shorter than the debounce window are rejected.
    for (int w = 1; w <= 3; w++) begin
      key_i = 1'b0;
      cycles(w);
      key_i = 1'b1;
      cycles(8);
    end
    do_load(STATUS, 32'h0000_0106, "status_after_glitches");
    check("irq_after_glitches", {31'h0, irq_o}, 32'h0);

    // A second press sets pending again.
    press();
    check("irq_second_press", {31'h0, irq_o}, 32'h1);

    // A clear lands in the same cycle as the third press event: the set wins.
    key_i = 1'b0;
    cycles(5);
    do_store(CTRL, 32'h3);
    check("irq_set_wins", {31'h0, irq_o}, 32'h1);
    cycles(2);
    check("irq_still_set", {31'h0, irq_o}, 32'h1);
    do_load(STATUS, 32'h0000_0305, "status_set_wins");
    key_i = 1'b1;
    cycles(8);
    do_store(CTRL, 32'h3);
    check("irq_hold_clear2", {31'h0, irq_o}, 32'h1);
    cycles(1);
    check("irq_dropped2", {31'h0, irq_o}, 32'h0);
    do_load(STATUS, 32'h0000_0306, "status_cleared2");

    // Wrap press_cnt: 3 presses so far, 252 more reach 0xFF, then one more wraps.
    repeat (252) press();
    do_load(STATUS, 32'h0000_FF07, "status_cnt_ff");
    press();
    do_load(STATUS, 32'h0000_0007, "status_cnt_wrap");
    check("irq_after_wrap", {31'h0, irq_o}, 32'h1);

    // Vector write and read, an unmapped load, and dout hold.
    do_store(VECTOR, 32'h0000_0180);
    check("vec_written", irq_addr_o, 32'h0000_0180);
    do_load(VECTOR, 32'h0000_0180, "vector_readback");
    do_load(BASE + 32'hC, 32'h0, "unmapped_load");
    do_store(STATUS, 32'hFFFF_FFFF);
    cycles(2);
    bus.addr_i     = STATUS;
    bus.dmem_ctl_i = 4'h5;
    cycles(1);
    bus.dmem_ctl_i = 4'h0;
    check("dout_hold", bus.dout, 32'h0);
    do_load(STATUS, 32'h0000_0007, "status_ro_and_ignored");

    // Assert reset asynchronously while irq_o is high and the debounce count is running.
    key_i = 1'b0;
    cycles(4);
    #2 rst = 1'b0;
    #1;
    check("async_rst_irq", {31'h0, irq_o}, 32'h0);
    check("async_rst_vec", irq_addr_o, 32'h0000_0050);
    check("async_rst_dout", bus.dout, 32'h0);
    key_i = 1'b1;
    cycles(2);
    rst = 1'b1;
    cycles(1);
    do_load(STATUS, 32'h0000_0002, "status_after_rst2");
    cycles(6);
    check("irq_after_rst2", {31'h0, irq_o}, 32'h0);
    check("vec_after_rst2", irq_addr_o, 32'h0000_0050);

    cycles(2);
    check("scoreboard_drain", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
